// File: rtl/memory_read_arbiter_if.sv
// Request/response bundle between two ROM requesters, the arbiter and the ROM wrapper.
// The slave modport is the arbiter side; the master modport is the requester/ROM side.
interface memory_read_arbiter_if #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             a_valid;
    logic [AW-1:0]    a_addr;
    logic             a_ready;
    logic             a_rvalid;
    logic [WIDTH-1:0] a_rdata;
    logic             a_rready;

    logic             b_valid;
    logic [AW-1:0]    b_addr;
    logic             b_ready;
    logic             b_rvalid;
    logic [WIDTH-1:0] b_rdata;
    logic             b_rready;

    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  a_valid, a_addr, a_rready,
        input  b_valid, b_addr, b_rready,
        input  mem_rdata,
        output a_ready, a_rvalid, a_rdata,
        output b_ready, b_rvalid, b_rdata,
        output mem_raddr
    );

    modport master (
        output a_valid, a_addr, a_rready,
        output b_valid, b_addr, b_rready,
        output mem_rdata,
        input  a_ready, a_rvalid, a_rdata,
        input  b_ready, b_rvalid, b_rdata,
        input  mem_raddr
    );
endinterface

// File: rtl/memory_read_arbiter.sv
// Round-robin sharing of one asynchronous-read ROM between two requesters,
// each with a one-entry registered response buffer (1-cycle latency).
module memory_read_arbiter #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input logic                  CLK,
    input logic                  RESET,
    memory_read_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Addresses past DEPTH exist when DEPTH is not a power of two; they read as zero.
    function automatic logic [WIDTH-1:0] range_mask(input logic [AW-1:0] addr,
                                                    input logic [WIDTH-1:0] word);
        return (int'(addr) < DEPTH) ? word : '0;
    endfunction

    logic             prio;
    logic             a_vld_p1, b_vld_p1;
    logic [WIDTH-1:0] a_data_p1, b_data_p1;

    logic             can_a, can_b, want_a, want_b, grant_a, grant_b;
    logic [AW-1:0]    raddr_p0;
    logic [WIDTH-1:0] fetch_p0;

    // Stage 0: eligibility, grant and combinational ROM lookup
    always_comb begin
        can_a   = !a_vld_p1 || bus.a_rready;
        can_b   = !b_vld_p1 || bus.b_rready;
        want_a  = bus.a_valid && can_a && !RESET;
        want_b  = bus.b_valid && can_b && !RESET;
        grant_a = want_a && (!want_b || !prio);
        grant_b = want_b && (!want_a || prio);
        raddr_p0 = '0;
        if (grant_a) begin
            raddr_p0 = bus.a_addr;
        end else if (grant_b) begin
            raddr_p0 = bus.b_addr;
        end
        fetch_p0 = range_mask(raddr_p0, bus.mem_rdata);
    end

    assign bus.a_ready   = grant_a;
    assign bus.b_ready   = grant_b;
    assign bus.mem_raddr = raddr_p0;

    // Stage 1: per-port response buffers and priority update
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prio      <= 1'b0;
            a_vld_p1  <= 1'b0;
            b_vld_p1  <= 1'b0;
            a_data_p1 <= '0;
            b_data_p1 <= '0;
        end else begin
            if (grant_a) begin
                a_data_p1 <= fetch_p0;
                a_vld_p1  <= 1'b1;
            end else if (bus.a_rready) begin
                a_vld_p1  <= 1'b0;
            end
            if (grant_b) begin
                b_data_p1 <= fetch_p0;
                b_vld_p1  <= 1'b1;
            end else if (bus.b_rready) begin
                b_vld_p1  <= 1'b0;
            end
            if (grant_a) begin
                prio <= 1'b1;
            end else if (grant_b) begin
                prio <= 1'b0;
            end
        end
    end

    assign bus.a_rvalid = a_vld_p1;
    assign bus.a_rdata  = a_data_p1;
    assign bus.b_rvalid = b_vld_p1;
    assign bus.b_rdata  = b_data_p1;
endmodule

// File: tb/tb_memory_read_arbiter.sv
// Directed and randomized checks of memory_read_arbiter against a transaction-level
// model; a second DEPTH=3 instance covers out-of-range addresses.
module tb_memory_read_arbiter;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic [19:0] img = 20'h04d47;

    memory_read_arbiter_if #(.WIDTH(5), .DEPTH(4)) bus4 ();
    memory_read_arbiter_if #(.WIDTH(5), .DEPTH(3)) bus3 ();

    memory_read_arbiter #(.WIDTH(5), .DEPTH(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus4));
    memory_read_arbiter #(.WIDTH(5), .DEPTH(3)) dut3 (.CLK(CLK), .RESET(RESET), .bus(bus3));

    // ROM wrappers; the DEPTH=3 one returns junk past its last entry.
    assign bus4.mem_rdata = img[5*int'(bus4.mem_raddr) +: 5];
    assign bus3.mem_rdata = (int'(bus3.mem_raddr) < 3) ? img[5*int'(bus3.mem_raddr) +: 5] : 5'h1F;

    int errors = 0;
    int checks = 0;

    // Reference model: who is owed the next tie-break, and each port's buffered word.
    int         m_next;
    bit         m_full [2];
    logic [4:0] m_word [2];

    function automatic logic [4:0] rom4(input int a);
        logic [19:0] im;
        im = 20'h04d47;
        return (a < 4) ? im[5*a +: 5] : 5'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst,
                        input bit va, input logic [1:0] aa, input bit ra,
                        input bit vb, input logic [1:0] ab, input bit rb);
        bit         req [2];
        bit         rr [2];
        logic [1:0] ad [2];
        int         winner;
        @(negedge CLK);
        RESET = rst;
        bus4.a_valid = va; bus4.a_addr = aa; bus4.a_rready = ra;
        bus4.b_valid = vb; bus4.b_addr = ab; bus4.b_rready = rb;
        req[0] = va; req[1] = vb; rr[0] = ra; rr[1] = rb; ad[0] = aa; ad[1] = ab;
        #1;
        winner = -1;
        if (!rst) begin
            for (int p = 0; p < 2; p++) begin
                if (req[p] && (!m_full[p] || rr[p])) begin
                    if (winner < 0 || p == m_next) winner = p;
                end
            end
        end
        chk("a_ready", {31'b0, bus4.a_ready}, (winner == 0) ? 1 : 0);
        chk("b_ready", {31'b0, bus4.b_ready}, (winner == 1) ? 1 : 0);
        chk("mem_raddr", {30'b0, bus4.mem_raddr}, (winner >= 0) ? {30'b0, ad[winner]} : 0);
        @(posedge CLK);
        #1;
        if (rst) begin
            m_next = 0;
            for (int p = 0; p < 2; p++) begin
                m_full[p] = 0;
                m_word[p] = 5'h00;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (winner == p) begin
                    m_full[p] = 1;
                    m_word[p] = rom4(int'(ad[p]));
                end else if (rr[p]) begin
                    m_full[p] = 0;
                end
            end
            if (winner >= 0) m_next = 1 - winner;
        end
        chk("a_rvalid", {31'b0, bus4.a_rvalid}, {31'b0, m_full[0]});
        chk("a_rdata", {27'b0, bus4.a_rdata}, {27'b0, m_word[0]});
        chk("b_rvalid", {31'b0, bus4.b_rvalid}, {31'b0, m_full[1]});
        chk("b_rdata", {27'b0, bus4.b_rdata}, {27'b0, m_word[1]});
    endtask

    initial begin
        m_next = 0;
        m_full[0] = 0; m_full[1] = 0;
        m_word[0] = 5'h00; m_word[1] = 5'h00;
        bus4.a_valid = 0; bus4.a_addr = 0; bus4.a_rready = 0;
        bus4.b_valid = 0; bus4.b_addr = 0; bus4.b_rready = 0;
        bus3.a_valid = 0; bus3.a_addr = 0; bus3.a_rready = 1;
        bus3.b_valid = 0; bus3.b_addr = 0; bus3.b_rready = 1;

        // Reset state, then A alone at addr 1 with rready high
        step(1, 1, 2'd1, 1, 0, 2'd0, 1);
        step(1, 1, 2'd1, 1, 0, 2'd0, 1);
        repeat (4) step(0, 1, 2'd1, 1, 0, 2'd0, 1);
        chk("a_rdata_0A", {27'b0, bus4.a_rdata}, 32'h0A);

        // Contention after reset: A and B alternate
        step(1, 0, 2'd0, 1, 0, 2'd0, 1);
        repeat (6) step(0, 1, 2'd0, 1, 1, 2'd2, 1);
        chk("b_rdata_13", {27'b0, bus4.b_rdata}, 32'h13);

        // Backpressure on A, B keeps flowing, then A re-granted when rready rises
        step(1, 0, 2'd0, 1, 0, 2'd0, 1);
        step(0, 1, 2'd2, 0, 1, 2'd1, 1);
        repeat (3) step(0, 1, 2'd1, 0, 1, 2'd1, 1);
        step(0, 1, 2'd1, 1, 1, 2'd3, 1);

        // Same-cycle drain and refill of A with addr 3
        step(0, 1, 2'd0, 1, 0, 2'd0, 1);
        step(0, 1, 2'd3, 1, 0, 2'd0, 1);
        chk("a_rdata_00", {27'b0, bus4.a_rdata}, 32'h00);

        // Mid-operation reset with both buffers full and B owed priority
        step(1, 0, 2'd0, 1, 0, 2'd0, 1);
        step(0, 0, 2'd0, 0, 1, 2'd2, 0);
        step(0, 1, 2'd1, 0, 1, 2'd2, 0);
        step(1, 1, 2'd1, 0, 1, 2'd2, 0);
        step(0, 1, 2'd0, 1, 1, 2'd2, 1);
        chk("a_first_after_reset", {31'b0, bus4.a_rvalid & ~bus4.b_rvalid}, 32'h1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 40) == 0,
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end

        // DEPTH=3 instance: out-of-range addr 3 reads zero, addr 2 reads normally
        @(negedge CLK);
        RESET = 0;
        bus3.a_valid = 1; bus3.a_addr = 2'd3; bus3.a_rready = 1;
        #1;
        chk("d3_ready", {31'b0, bus3.a_ready}, 32'h1);
        chk("d3_raddr", {30'b0, bus3.mem_raddr}, 32'h3);
        @(posedge CLK);
        #1;
        chk("d3_rvalid", {31'b0, bus3.a_rvalid}, 32'h1);
        chk("d3_rdata_oor", {27'b0, bus3.a_rdata}, 32'h0);
        @(negedge CLK);
        bus3.a_addr = 2'd2;
        @(posedge CLK);
        #1;
        chk("d3_rdata_2", {27'b0, bus3.a_rdata}, 32'h13);
        @(negedge CLK);
        bus3.a_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/memory_read_arbiter.md
# memory_read_arbiter

Two-port round-robin arbiter that shares a single asynchronous-read ROM (the `Memory`/`coreir_mem` read-only instance) between two independent requesters.
- Each requester issues addresses with a valid/ready handshake.
- Each requester receives its data from a registered response buffer that has its own valid/ready backpressure.
- Sits between the ROM wrapper and its consumers; the ROM itself is instantiated outside this block.

## Interface

Parameters:
- `WIDTH`, 5, data width of the ROM word.
- `DEPTH`, 4, number of valid ROM entries; `AW = $clog2(DEPTH)`, minimum 1.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A presents an address.
- `a_addr`  in  AW  requester A read address.
- `a_ready`  out  1  requester A request accepted this cycle.
- `a_rvalid`  out  1  requester A response buffer holds data.
- `a_rdata`  out  WIDTH  requester A response data.
- `a_rready`  in  1  requester A consumes its response.
- `b_valid`, `b_addr`, `b_ready`, `b_rvalid`, `b_rdata`, `b_rready`: identical set for requester B.
- `mem_raddr`  out  AW  address to the ROM `RADDR`.
- `mem_rdata`  in  WIDTH  ROM `RDATA`; combinational in `mem_raddr`.

## Operation

State:
- `prio`: 1 bit; 0 means A has priority, 1 means B has priority.
- Per port: `rvalid` flag and `rdata` register.

Eligibility:
- `can_x = !x_rvalid | x_rready`. The buffer is empty, or it drains this cycle.

Grant, computed combinationally each cycle:
- `want_x = x_valid & can_x & !RESET`.
- If only one port wants, that port is granted.
- If both want, the port indicated by `prio` is granted.
- At most one grant per cycle.
- `x_ready` = grant to x.
- `x_ready` may depend on the other port's `x_valid`. Requesters must not make `valid` depend on `ready`.

ROM address:
- `mem_raddr` = granted port's `addr`.
- With no grant, `mem_raddr` = 0.

On a grant to x at a clock edge:
- `x_rdata <= (addr < DEPTH) ? mem_rdata : 0`. Out-of-range addresses, which are possible when DEPTH is not a power of 2, return all zeros.
- `x_rvalid <= 1`.
- `prio <=` the other port.

Response drain:
- If `x_rvalid & x_rready` and no new grant to x: `x_rvalid <= 0`. `x_rdata` holds its last value.
- Drain and re-grant in the same cycle: `x_rvalid` stays 1 and `x_rdata` takes the new word (back-to-back throughput of 1 per cycle per port).

Other rules:
- No grant: `prio` unchanged.
- A port whose buffer is full and not draining is never granted. The other port may be granted even if it lacks priority; `prio` then flips as normal.
- Reset values: `a_rvalid = b_rvalid = 0`, `a_rdata = b_rdata = 0`, `prio = 0` (A first).
- `a_ready = b_ready = 0` while RESET is high.
- `mem_raddr = 0` while RESET is high.
- RESET mid-transfer discards any buffered response.

## Timing

- Request to response latency is 1 cycle: accept at edge t, so `x_rvalid = 1` and `x_rdata` are valid after edge t.
- `x_rvalid`/`x_rdata` are registered outputs.
- `x_ready` and `mem_raddr` are combinational from valid, addr, rready and state.
- Sustained throughput:
  - 1 grant per cycle total.
  - Each port gets 1 grant per 2 cycles under continuous contention.
  - A lone requester with `rready` held high gets 1 grant per cycle.
- Response data stays stable while `x_rvalid & !x_rready`.

## Test plan

ROM image for all scenarios: 20'h04d47, WIDTH=5, DEPTH=4, so entries 0..3 = 5'h07, 5'h0A, 5'h13, 5'h00.

1. Reset, then A alone:
   - Stimulus: `a_addr=1`, `a_valid=1`, `a_rready=1`.
   - Response: `a_ready=1` every cycle; `a_rvalid=1` from the next cycle; `a_rdata=5'h0A`.
   - B stays idle: `b_rvalid=0`.
2. Contention after reset:
   - Stimulus: both valid continuously, `a_addr=0`, `b_addr=2`, both rready=1.
   - Response: grants alternate A, B, A, B. `a_rdata=5'h07` and `b_rdata=5'h13`, each rvalid stays 1 after its first grant.
3. Backpressure:
   - Stimulus: A granted once with `a_rready=0`, `a_valid` held, B valid.
   - Response: A is not granted again; `a_rdata` is held at its value; B is granted every cycle.
   - Then raise `a_rready`: A is re-granted in that same cycle.
4. Same-cycle drain and refill:
   - Stimulus: `a_rvalid=1`, `a_rready=1`, A requests addr 3.
   - Response: `a_rvalid` stays 1 and `a_rdata` becomes 5'h00 at the next edge, with no bubble.
5. Out-of-range address:
   - Stimulus: instantiate DEPTH=3 (AW=2), request addr 3.
   - Response: `rdata=0`, `rvalid=1`.
6. Mid-operation reset:
   - Stimulus: assert RESET while both buffers are full and `prio=1`.
   - Response at the next edge: both rvalid=0, both rdata=0, readies low during reset.
   - After release with both requesting: A is granted first.
